// File: rtl/gate_to_pulse.sv
// Converts an asynchronous stretched gate into one clean pulse plus a measured gate width.
// Short gates are rejected and counted. Input is ignored for a blanking window after reset and briefly after each gate.
//
// state  | meaning
// BLANK  | post-reset window, input ignored
// ARM    | wait for inactive input so a gate already in progress is never caught mid-way
// IDLE   | waiting for a gate
// QUAL   | gate seen, counting toward MIN_W
// ACTIVE | gate qualified, pulse issued, measuring width
// HOLD   | post-gate holdoff, input ignored
module gate_to_pulse #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_W       = 2,
    parameter int HOLDOFF     = 4,
    parameter int CW          = 8,
    parameter int BLANK       = 240
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          polarity_i,
    input  logic          pulse_i,
    output logic          pulse_o,
    output logic          npulse_o,
    output logic [CW-1:0] width_o,
    output logic          width_valid_o,
    output logic [7:0]    glitch_cnt_o,
    output logic          busy_o
);

    localparam int TMAX = (BLANK > HOLDOFF) ? BLANK : HOLDOFF;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLDOFF - 1);
    localparam logic [TW-1:0] T_ONE      = TW'(1);
    localparam logic [CW-1:0] W_ONE      = CW'(1);
    localparam logic [CW-1:0] W_MAX      = {CW{1'b1}};
    localparam logic [CW-1:0] MIN_W_C    = CW'(MIN_W);

    typedef enum logic [2:0] {
        ST_BLANK,
        ST_ARM,
        ST_IDLE,
        ST_QUAL,
        ST_ACTIVE,
        ST_HOLD
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_q;
    logic [TW-1:0]          r_tmr;
    logic [CW-1:0]          r_wcnt;
    logic [CW-1:0]          w_wcnt_inc;

    assign w_wcnt_inc = r_wcnt + W_ONE;

    // The polarity compare is registered so q is glitch-free and adds one fixed cycle of latency.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_sync <= '0;
            r_q    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_i};
            r_q    <= ~(r_sync[SYNC_STAGES-1] ^ polarity_i);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state       <= ST_BLANK;
            r_tmr         <= '0;
            r_wcnt        <= '0;
            pulse_o       <= 1'b0;
            npulse_o      <= 1'b1;
            width_o       <= '0;
            width_valid_o <= 1'b0;
            glitch_cnt_o  <= '0;
            busy_o        <= 1'b1;
        end else begin
            pulse_o       <= 1'b0;
            npulse_o      <= 1'b1;
            width_valid_o <= 1'b0;
            case (r_state)
                ST_BLANK: begin
                    if (r_tmr == BLANK_LAST) begin
                        r_tmr   <= '0;
                        r_state <= ST_ARM;
                    end else begin
                        r_tmr <= r_tmr + T_ONE;
                    end
                end
                ST_ARM: begin
                    if (!r_q) begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (r_q) begin
                        r_wcnt <= W_ONE;
                        busy_o <= 1'b1;
                        if (MIN_W == 1) begin
                            pulse_o  <= 1'b1;
                            npulse_o <= 1'b0;
                            r_state  <= ST_ACTIVE;
                        end else begin
                            r_state <= ST_QUAL;
                        end
                    end
                end
                ST_QUAL: begin
                    if (r_q) begin
                        r_wcnt <= w_wcnt_inc;
                        if (w_wcnt_inc == MIN_W_C) begin
                            pulse_o  <= 1'b1;
                            npulse_o <= 1'b0;
                            r_state  <= ST_ACTIVE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                        if (glitch_cnt_o != 8'hFF)
                            glitch_cnt_o <= glitch_cnt_o + 8'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (r_q) begin
                        if (r_wcnt != W_MAX)
                            r_wcnt <= w_wcnt_inc;
                    end else begin
                        width_o       <= r_wcnt;
                        width_valid_o <= 1'b1;
                        r_tmr         <= HOLD_LOAD;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_tmr == '0)
                        r_state <= ST_ARM;
                    else
                        r_tmr <= r_tmr - T_ONE;
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_tmr   <= '0;
                    busy_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_to_pulse.md
GATE_TO_PULSE -- requirements
Module: gate_to_pulse

Interface
REQ-001 Parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-002 Parameter MIN_W, default 2: consecutive active cycles required to qualify a gate, minimum 1.
REQ-003 Parameter HOLDOFF, default 4: input-ignore cycles after gate end, minimum 1.
REQ-004 Parameter CW, default 8: width counter and width_o bits.
REQ-005 Parameter BLANK, default 240: post-reset input-ignore cycles.
REQ-006 clk_i  input  1  clock; all logic on rising edge.
REQ-007 resetn_i  input  1  reset, asynchronous, active-low.
REQ-008 polarity_i  input  1  1/0 = pulse_i is positive/negative logic; quasi-static.
REQ-009 pulse_i  input  1  asynchronous gate (stretched level) to convert.
REQ-010 pulse_o  output  1  single-cycle positive-logic pulse per qualified gate.
REQ-011 npulse_o  output  1  always the inverse of pulse_o.
REQ-012 width_o  output  CW  measured gate length in clocks, held until the next update.
REQ-013 width_valid_o  output  1  one-cycle strobe marking a width_o update.
REQ-014 glitch_cnt_o  output  8  count of rejected sub-MIN_W gates, saturating at 255.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 pulse_i SHALL pass through SYNC_STAGES flops, then be XNORed with polarity_i to form q (1 = active).
REQ-017 FSM states SHALL be BLANK, ARM, IDLE, QUAL, ACTIVE and HOLD; the reset state is BLANK.
REQ-018 BLANK SHALL count BLANK cycles, ignoring q, then go to ARM.
REQ-019 ARM SHALL go to IDLE only on a cycle with q=0, so a gate already active is never detected mid-gate.
REQ-020 IDLE with q=1 SHALL load wcnt=1 and go to QUAL, or to ACTIVE with pulse_o if MIN_W=1.
REQ-021 QUAL with q=1 SHALL increment wcnt; on reaching MIN_W it SHALL assert pulse_o for exactly one cycle and go to ACTIVE.
REQ-022 QUAL with q=0 SHALL return to IDLE, increment glitch_cnt_o (saturating at 255), and leave pulse_o and width_o untouched.
REQ-023 ACTIVE with q=1 SHALL increment wcnt, saturating at 2^CW-1 with no wrap.
REQ-024 ACTIVE with q=0 SHALL load width_o=wcnt, strobe width_valid_o for one cycle, load the holdoff counter and go to HOLD.
REQ-025 HOLD SHALL ignore q for HOLDOFF cycles, then go to ARM.
REQ-026 pulse_o SHALL rise exactly SYNC_STAGES+MIN_W clocks after the first rising edge sampling pulse_i active, and at most once per gate.
REQ-027 width_valid_o SHALL rise SYNC_STAGES+1 clocks after the first edge sampling pulse_i inactive.
REQ-028 width_o SHALL equal the number of consecutive q=1 cycles, including qualification cycles.
REQ-029 All outputs SHALL be registered.
REQ-030 A polarity_i change SHALL be treated as an input edge; no extra protection is provided.

Reset
REQ-031 On resetn_i low, the FSM SHALL enter BLANK, all counters and synchronizer flops SHALL clear, and outputs SHALL be: pulse_o=0, npulse_o=1, width_o=0, width_valid_o=0, glitch_cnt_o=0, busy_o=1.
REQ-032 Reset asserted in any state, including mid-gate, SHALL abort it with no pulse_o or width strobe, and BLANK SHALL restart after release.

Verification
REQ-033 polarity_i=1, pulse_i high from reset release to cycle 300, then a 6-cycle gate at cycle 400 -> no pulse_o before cycle 400, then one pulse_o, width_o=6, glitch_cnt_o=0.
REQ-034 After blanking, a 1-cycle gate -> no pulse_o, no width_valid_o, glitch_cnt_o=1; 256 such gates -> glitch_cnt_o=255.
REQ-035 A 300-cycle gate -> exactly one pulse_o 4 clocks after the rising edge, width_o=255 (saturated).
REQ-036 polarity_i=0, pulse_i low for 5 cycles -> one pulse_o, width_o=5, npulse_o inverse throughout.
REQ-037 A 5-cycle gate, 2 cycles low, then a 10-cycle gate -> one pulse_o only, with the second gate ignored via HOLD then ARM, and one width_valid_o with width_o=5.
REQ-038 resetn_i pulsed low during ACTIVE -> reset values on all outputs immediately, no width_valid_o, and no pulse_o detectable for 240 cycles.
